// File: rtl/multi_reg_display_if.sv
//-----------------------------------------------------------------------------
// multi_reg_display_if
//   Bundle of the register-tap inputs and the seven-segment outputs of
//   multi_reg_display.
//   master : the board/debug side; drives taps and selection, sees the display
//   slave  : the display scanner itself
//
//   ch_data    32*NUM_CH  flat register taps, channel k = ch_data[32k+31:32k]
//   sel_mode   1          0 = manual select, 1 = auto-cycle
//   sel_manual CW         channel index used in manual mode
//   blank_lz   1          1 = blank leading zero digits
//   out7       7          segments {a,b,c,d,e,f,g}, active low
//   en_out     NUM_DIGITS digit anodes, one-hot active low
//   cur_ch     CW         channel currently displayed
//
//   There is no valid/ready handshake on this bundle: every input is a level
//   that the scanner samples on each rising clock edge, and every output is a
//   register that is valid at all times.
//-----------------------------------------------------------------------------
`timescale 1ns/1ps
interface multi_reg_display_if #(
  parameter int NUM_CH     = 4,
  parameter int NUM_DIGITS = 8
);
  localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [32*NUM_CH-1:0]  ch_data;
  logic                  sel_mode;
  logic [CW-1:0]         sel_manual;
  logic                  blank_lz;
  logic [6:0]            out7;
  logic [NUM_DIGITS-1:0] en_out;
  logic [CW-1:0]         cur_ch;

  modport master (
    output ch_data, sel_mode, sel_manual, blank_lz,
    input  out7, en_out, cur_ch
  );

  modport slave (
    input  ch_data, sel_mode, sel_manual, blank_lz,
    output out7, en_out, cur_ch
  );
endinterface

// File: rtl/multi_reg_display.sv
//-----------------------------------------------------------------------------
// multi_reg_display
//   Multi-channel seven-segment scanner for board-level processor debug.
//   Selects one of NUM_CH 32-bit register taps (manually or by timed
//   auto-cycling), snapshots it into a shadow register at frame boundaries or
//   on a channel change, and scans it in hex across NUM_DIGITS multiplexed
//   digits with optional leading-zero blanking.
//
//   Clk    in  system clock, all state on the rising edge
//   Reset  in  asynchronous, active-high reset
//   bus    slave side of multi_reg_display_if (taps, selection, display)
//-----------------------------------------------------------------------------
`timescale 1ns/1ps
module multi_reg_display #(
  parameter int NUM_DIGITS  = 8,
  parameter int NUM_CH      = 4,
  parameter int REFRESH_DIV = 100000,
  parameter int DWELL_DIV   = 100000000
) (
  input logic               Clk,
  input logic               Reset,
  multi_reg_display_if.slave bus
);

  localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int RW = $clog2(REFRESH_DIV);
  localparam int DW = $clog2(DWELL_DIV);
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [RW-1:0] REFRESH_LAST = RW'(REFRESH_DIV - 1);
  localparam logic [DW-1:0] DWELL_LAST   = DW'(DWELL_DIV - 1);
  localparam logic [IW-1:0] DIGIT_LAST   = IW'(NUM_DIGITS - 1);
  localparam logic [CW-1:0] CH_LAST      = CW'(NUM_CH - 1);

  logic [RW-1:0]         refresh_cnt;
  logic [DW-1:0]         dwell_cnt;
  logic [IW-1:0]         digit_idx;
  logic [CW-1:0]         cur_ch;
  logic [CW-1:0]         prev_ch;
  logic [31:0]           shadow;
  logic                  blank_q;
  logic [6:0]            out7_q;
  logic [NUM_DIGITS-1:0] en_q;

  logic                  refresh_tc;
  logic                  dwell_tc;
  logic                  ch_changed;
  logic [CW-1:0]         manual_ch;
  logic [CW-1:0]         auto_ch;
  logic [CW-1:0]         next_ch;
  logic [31:0]           sel_word;
  logic [3:0]            nibble;
  logic                  blank_slot;
  logic [6:0]            seg;
  logic [NUM_DIGITS-1:0] en_next;

  assign refresh_tc = (refresh_cnt == REFRESH_LAST);
  assign dwell_tc   = (dwell_cnt == DWELL_LAST);
  // cur_ch was updated last edge, so a mismatch with prev_ch means the
  // reload for the new channel happens on this edge.
  assign ch_changed = (cur_ch != prev_ch);

  // Out-of-range manual indices pin to the last channel.
  assign manual_ch = (bus.sel_manual > CH_LAST) ? CH_LAST : bus.sel_manual;
  assign auto_ch   = (cur_ch == CH_LAST) ? '0 : cur_ch + CW'(1);

  always_comb begin
    next_ch = cur_ch;
    if (!bus.sel_mode) begin
      next_ch = manual_ch;
    end else if (dwell_tc) begin
      next_ch = auto_ch;
    end
  end

  // Channel mux for the shadow load.
  always_comb begin
    sel_word = bus.ch_data[31:0];
    for (int k = 0; k < NUM_CH; k++) begin
      if (cur_ch == CW'(k)) sel_word = bus.ch_data[32*k +: 32];
    end
  end

  // Current digit nibble, anode pattern, and whether this slot lies in the
  // all-zero upper run of the shadow word (digit 0 is never blanked).
  always_comb begin
    nibble     = shadow[3:0];
    blank_slot = blank_q && (digit_idx != '0);
    en_next    = '1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (digit_idx == IW'(i)) begin
        nibble     = shadow[4*i +: 4];
        en_next[i] = 1'b0;
      end
      if ((IW'(i) >= digit_idx) && (shadow[4*i +: 4] != 4'h0)) blank_slot = 1'b0;
    end
  end

  // Hex to active-low {a,b,c,d,e,f,g}.
  always_comb begin
    seg = 7'h7F;
    case (nibble)
      4'h0: seg = 7'b0000001;
      4'h1: seg = 7'b1001111;
      4'h2: seg = 7'b0010010;
      4'h3: seg = 7'b0000110;
      4'h4: seg = 7'b1001100;
      4'h5: seg = 7'b0100100;
      4'h6: seg = 7'b0100000;
      4'h7: seg = 7'b0001111;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0000100;
      4'hA: seg = 7'b0001000;
      4'hB: seg = 7'b1100000;
      4'hC: seg = 7'b0110001;
      4'hD: seg = 7'b1000010;
      4'hE: seg = 7'b0110000;
      4'hF: seg = 7'b0111000;
      default: seg = 7'h7F;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      refresh_cnt <= '0;
      dwell_cnt   <= '0;
      digit_idx   <= '0;
      cur_ch      <= '0;
      prev_ch     <= '0;
      shadow      <= '0;
      blank_q     <= 1'b0;
      out7_q      <= 7'h7F;
      en_q        <= '1;
    end else begin
      prev_ch <= cur_ch;
      cur_ch  <= next_ch;

      // Dwell only runs in auto mode; manual mode holds it at zero so a
      // switch back to auto always starts a full dwell period.
      if (!bus.sel_mode || dwell_tc) begin
        dwell_cnt <= '0;
      end else begin
        dwell_cnt <= dwell_cnt + DW'(1);
      end

      // A channel change takes priority over a coincident frame boundary so
      // the shadow reloads only once, from the new channel. blank_lz is
      // captured whenever a new slot starts so it is stable for the slot.
      if (ch_changed) begin
        shadow      <= sel_word;
        digit_idx   <= '0;
        refresh_cnt <= '0;
        blank_q     <= bus.blank_lz;
      end else if (refresh_tc) begin
        refresh_cnt <= '0;
        blank_q     <= bus.blank_lz;
        if (digit_idx == DIGIT_LAST) begin
          digit_idx <= '0;
          shadow    <= sel_word;
        end else begin
          digit_idx <= digit_idx + IW'(1);
        end
      end else begin
        refresh_cnt <= refresh_cnt + RW'(1);
      end

      // Segments and anodes come from the same idx/shadow so they move together.
      out7_q <= blank_slot ? 7'h7F : seg;
      en_q   <= blank_slot ? '1 : en_next;
    end
  end

  assign bus.out7   = out7_q;
  assign bus.en_out = en_q;
  assign bus.cur_ch = cur_ch;

endmodule

// File: tb/tb_multi_reg_display.sv
`timescale 1ns/1ps
module tb_multi_reg_display;

  localparam int ND   = 8;
  localparam int NCH  = 4;
  localparam int RDIV = 4;
  localparam int DDIV = 20;
  localparam int SLOTS_PER_DWELL = DDIV / RDIV;

  localparam int ND3   = 4;
  localparam int NCH3  = 3;
  localparam int RDIV3 = 2;
  localparam int DDIV3 = 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // expected {en_out, out7} per display slot
  logic [14:0] exp_q[$];
  logic [31:0] chv[NCH];

  multi_reg_display_if #(.NUM_CH(NCH),  .NUM_DIGITS(ND))  bus  ();
  multi_reg_display_if #(.NUM_CH(NCH3), .NUM_DIGITS(ND3)) bus3 ();

  multi_reg_display #(
    .NUM_DIGITS(ND), .NUM_CH(NCH), .REFRESH_DIV(RDIV), .DWELL_DIV(DDIV)
  ) u_dut (
    .Clk(clk), .Reset(rst), .bus(bus)
  );

  multi_reg_display #(
    .NUM_DIGITS(ND3), .NUM_CH(NCH3), .REFRESH_DIV(RDIV3), .DWELL_DIV(DDIV3)
  ) u_dut3 (
    .Clk(clk), .Reset(rst), .bus(bus3)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference helpers ----------------
  function automatic logic [6:0] seg_of(input logic [3:0] n);
    case (n)
      4'h0: return 7'b0000001;
      4'h1: return 7'b1001111;
      4'h2: return 7'b0010010;
      4'h3: return 7'b0000110;
      4'h4: return 7'b1001100;
      4'h5: return 7'b0100100;
      4'h6: return 7'b0100000;
      4'h7: return 7'b0001111;
      4'h8: return 7'b0000000;
      4'h9: return 7'b0000100;
      4'hA: return 7'b0001000;
      4'hB: return 7'b1100000;
      4'hC: return 7'b0110001;
      4'hD: return 7'b1000010;
      4'hE: return 7'b0110000;
      default: return 7'b0111000;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_ch(input int k, input logic [31:0] v);
    bus.ch_data[32*k +: 32] = v;
  endtask

  // Leaves the bench on a falling edge with reset still asserted.
  task automatic reset_and_check();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("rst_en_out", bus.en_out, 8'hFF);
    chk("rst_out7", bus.out7, 7'h7F);
    chk("rst_cur_ch", bus.cur_ch, 0);
    chk("rst3_en_out", bus3.en_out, 4'hF);
    chk("rst3_out7", bus3.out7, 7'h7F);
  endtask

  // ---------------- scoreboard ----------------
  task automatic push_slots(input logic [31:0] word, input logic blank,
                            input int first, input int count);
    for (int s = first; s < first + count; s++) begin
      int          i;
      logic [7:0]  en;
      logic [6:0]  sg;
      i = s % ND;
      if (blank && i != 0 && (word >> (4*i)) == 32'h0) begin
        en = 8'hFF;
        sg = 7'h7F;
      end else begin
        en = ~(8'h01 << i);
        sg = seg_of(word[4*i +: 4]);
      end
      exp_q.push_back({en, sg});
    end
  endtask

  // Each popped slot must hold for RDIV consecutive cycles.
  task automatic check_slots(input int n);
    logic [14:0] e;
    for (int s = 0; s < n; s++) begin
      if (exp_q.size() == 0) begin
        n_assert++;
        n_fail++;
        $error("FAIL scoreboard_empty: observed 0 entries expected 1");
        return;
      end
      e = exp_q.pop_front();
      for (int k = 0; k < RDIV; k++) begin
        @(posedge clk);
        @(negedge clk);
        chk($sformatf("slot%0d_cyc%0d", s, k), {bus.en_out, bus.out7}, e);
      end
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst             = 1'b1;
    bus.ch_data     = '0;
    bus.sel_mode    = 1'b0;
    bus.sel_manual  = '0;
    bus.blank_lz    = 1'b0;
    bus3.ch_data    = '0;
    bus3.sel_mode   = 1'b0;
    bus3.sel_manual = '0;
    bus3.blank_lz   = 1'b0;
    chv[0] = 32'h76543210;
    chv[1] = 32'hFEDCBA98;
    chv[2] = 32'h13579BDF;
    chv[3] = 32'h2468ACE0;

    // T1: plain scan; first frame shows the reset shadow, then the channel.
    reset_and_check();
    set_ch(0, 32'h0123ABCD);
    rst = 1'b0;
    push_slots(32'h0, 1'b0, 0, ND);
    push_slots(32'h0123ABCD, 1'b0, 0, ND);
    push_slots(32'h0123ABCD, 1'b0, 0, 1);
    check_slots(2*ND + 1);

    // T6: manual switch to ch2, then reset between clock edges mid-frame.
    set_ch(2, 32'h55AA55A7);
    bus.sel_manual = 2'd2;
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
    end
    chk("man_cur_ch2", bus.cur_ch, 2);
    chk("man_ch2_slot0", {bus.en_out, bus.out7}, {8'hFE, seg_of(4'h7)});
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_en_out", bus.en_out, 8'hFF);
    chk("async_rst_out7", bus.out7, 7'h7F);
    chk("async_rst_cur_ch", bus.cur_ch, 0);
    bus.sel_manual = 2'd0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    push_slots(32'h0, 1'b0, 0, ND);
    push_slots(32'h0123ABCD, 1'b0, 0, 1);
    check_slots(ND + 1);

    // T2: leading-zero blanking.
    reset_and_check();
    set_ch(0, 32'h000000A5);
    bus.blank_lz = 1'b1;
    rst = 1'b0;
    push_slots(32'h0, 1'b1, 0, ND);
    push_slots(32'h000000A5, 1'b1, 0, ND);
    check_slots(2*ND);

    // T3: auto-cycling across all channels, wrapping back to 0.
    reset_and_check();
    bus.blank_lz = 1'b0;
    for (int c = 0; c < NCH; c++) set_ch(c, chv[c]);
    bus.sel_mode = 1'b1;
    rst = 1'b0;
    for (int k = 1; k <= DDIV; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (k == DDIV - 1) chk("auto_hold_ch0", bus.cur_ch, 0);
    end
    chk("auto_step_ch1", bus.cur_ch, 1);
    @(posedge clk);
    @(negedge clk);
    for (int c = 1; c <= NCH; c++) begin
      push_slots(chv[c % NCH], 1'b0, 0, SLOTS_PER_DWELL);
      check_slots(SLOTS_PER_DWELL);
      chk($sformatf("auto_step_after_ch%0d", c % NCH), bus.cur_ch, (c + 1) % NCH);
    end

    // T5: tap changes mid-frame stay hidden until the next frame.
    reset_and_check();
    bus.sel_mode = 1'b0;
    set_ch(0, 32'h11111111);
    rst = 1'b0;
    push_slots(32'h0, 1'b0, 0, ND);
    push_slots(32'h11111111, 1'b0, 0, ND);
    check_slots(ND + 3);
    set_ch(0, 32'h22222222);
    check_slots(ND - 3);
    push_slots(32'h22222222, 1'b0, 0, ND);
    check_slots(ND);

    // T4: 3-channel instance, select latency, clamp, auto wrap 2 -> 0.
    bus3.ch_data[32*2 +: 32] = 32'h00009876;
    chk("clamp_start", bus3.cur_ch, 0);
    bus3.sel_manual = 2'd1;
    @(posedge clk);
    @(negedge clk);
    chk("sel_latency", bus3.cur_ch, 1);
    bus3.sel_manual = 2'd3;
    @(posedge clk);
    @(negedge clk);
    chk("sel_clamp", bus3.cur_ch, 2);
    repeat (2) begin
      @(posedge clk);
      @(negedge clk);
    end
    chk("clamp_slot0", {bus3.en_out, bus3.out7}, {4'hE, seg_of(4'h6)});
    bus3.sel_mode = 1'b1;
    for (int k = 1; k <= DDIV3; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (k == DDIV3 - 1) chk("auto3_hold", bus3.cur_ch, 2);
    end
    chk("auto3_wrap", bus3.cur_ch, 0);
    repeat (DDIV3) begin
      @(posedge clk);
      @(negedge clk);
    end
    chk("auto3_next", bus3.cur_ch, 1);

    chk("queue_drained", exp_q.size(), 0);

    // ---------------- report ----------------
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
